// File: rtl/qed_dup_scheduler.sv
// Phase sequencer for the QED instruction cache: mirrors the cache fill level and
// drives exec_dup through original, duplicate and drain phases, pulsing qed_check per round.
module qed_dup_scheduler #(
    parameter int unsigned ICACHESIZE   = 16,
    parameter int unsigned ADDRESSSIZE  = $clog2(ICACHESIZE),
    parameter int unsigned ORIG_BUDGET  = 8,
    parameter int unsigned DRAIN_CYCLES = 5,
    parameter int unsigned TIMEOUT      = 64,
    parameter int unsigned ROUND_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   qed_enable,
    input  logic                   force_dup,
    input  logic                   IF_stall,
    input  logic [31:0]            ifu_qed_instruction,
    output logic                   exec_dup,
    output logic                   qed_check,
    output logic [ADDRESSSIZE-1:0] occupancy,
    output logic [ROUND_W-1:0]     round_cnt,
    output logic [1:0]             state
);

    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned DRN_W = $clog2(DRAIN_CYCLES + 1);

    localparam logic [ADDRESSSIZE-1:0] OCC_FULL   = ADDRESSSIZE'(ICACHESIZE - 1);
    localparam logic [ADDRESSSIZE-1:0] OCC_BUDGET = ADDRESSSIZE'(ORIG_BUDGET);
    localparam logic [ADDRESSSIZE-1:0] OCC_ONE    = ADDRESSSIZE'(1);
    localparam logic [TMO_W-1:0]       TMO_LAST   = TMO_W'(TIMEOUT - 1);
    localparam logic [DRN_W-1:0]       DRN_LAST   = DRN_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ORIG  = 2'd1,
        S_DUP   = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic                   exec_dup_q, exec_dup_d;
    logic                   qed_check_q, qed_check_d;
    logic [ADDRESSSIZE-1:0] occ_q, occ_d;
    logic [ROUND_W-1:0]     round_q, round_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [DRN_W-1:0]       drn_q, drn_d;

    logic nop, ins, del, occ_nz, tmo_hit, to_dup;
    logic unused_instr_bits;

    // Same insert/delete qualification the cache itself uses
    assign nop    = (ifu_qed_instruction[6:0] == 7'b1111111);
    assign ins    = (state_q == S_ORIG) && !IF_stall && !nop && (occ_q != OCC_FULL);
    assign del    = (state_q == S_DUP) && !IF_stall && (occ_q != '0);
    assign occ_nz = (occ_q != '0);
    assign unused_instr_bits = ^ifu_qed_instruction[31:7];

    always_comb begin
        state_d     = state_q;
        occ_d       = occ_q;
        tmo_d       = tmo_q;
        drn_d       = drn_q;
        round_d     = round_q;
        qed_check_d = 1'b0;
        tmo_hit     = 1'b0;
        to_dup      = 1'b0;

        if (ins) begin
            occ_d = occ_q + OCC_ONE;
        end else if (del) begin
            occ_d = occ_q - OCC_ONE;
        end

        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                drn_d = '0;
                if (qed_enable) begin
                    state_d = S_ORIG;
                end
            end
            S_ORIG: begin
                // Timeout measures fetch starvation only while something is captured
                tmo_hit = !ins && occ_nz && (tmo_q == TMO_LAST);
                if (ins || !occ_nz) begin
                    tmo_d = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
                to_dup = (occ_d != '0) &&
                         ((occ_d == OCC_BUDGET) || (occ_d == OCC_FULL) ||
                          force_dup || tmo_hit || !qed_enable);
                if (to_dup) begin
                    state_d = S_DUP;
                    tmo_d   = '0;
                end else if (!qed_enable && (occ_d == '0)) begin
                    state_d = S_IDLE;
                end
            end
            S_DUP: begin
                if (del && (occ_q == OCC_ONE)) begin
                    state_d = S_DRAIN;
                    drn_d   = '0;
                end
            end
            S_DRAIN: begin
                if (drn_q == DRN_LAST) begin
                    qed_check_d = 1'b1;
                    round_d     = round_q + ROUND_W'(1);
                    drn_d       = '0;
                    state_d     = qed_enable ? S_ORIG : S_IDLE;
                end else begin
                    drn_d = drn_q + DRN_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        exec_dup_d = (state_d == S_DUP) || (state_d == S_DRAIN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            exec_dup_q  <= 1'b0;
            qed_check_q <= 1'b0;
            occ_q       <= '0;
            round_q     <= '0;
            tmo_q       <= '0;
            drn_q       <= '0;
        end else begin
            state_q     <= state_d;
            exec_dup_q  <= exec_dup_d;
            qed_check_q <= qed_check_d;
            occ_q       <= occ_d;
            round_q     <= round_d;
            tmo_q       <= tmo_d;
            drn_q       <= drn_d;
        end
    end

    assign exec_dup  = exec_dup_q;
    assign qed_check = qed_check_q;
    assign occupancy = occ_q;
    assign round_cnt = round_q;
    assign state     = state_q;

endmodule

// File: tb/tb_qed_dup_scheduler.sv
// Directed bench for qed_dup_scheduler: default instance plus an ORIG_BUDGET=15 instance.
module tb_qed_dup_scheduler;

    localparam logic [31:0] I_ADD = 32'h0000_0013;
    localparam logic [31:0] I_NOP = 32'h0000_007F;

    logic clk, rst;
    logic qed_enable, force_dup, if_stall;
    logic [31:0] instr;
    logic        exec_dup, qed_check;
    logic [3:0]  occupancy;
    logic [15:0] round_cnt;
    logic [1:0]  state;

    logic        b_enable;
    logic [31:0] b_instr;
    logic        b_exec_dup, b_qed_check;
    logic [3:0]  b_occupancy;
    logic [15:0] b_round_cnt;
    logic [1:0]  b_state;

    int n_checks;
    int n_errors;
    int b_dup_entries;

    qed_dup_scheduler u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .qed_enable          (qed_enable),
        .force_dup           (force_dup),
        .IF_stall            (if_stall),
        .ifu_qed_instruction (instr),
        .exec_dup            (exec_dup),
        .qed_check           (qed_check),
        .occupancy           (occupancy),
        .round_cnt           (round_cnt),
        .state               (state)
    );

    qed_dup_scheduler #(.ORIG_BUDGET(15)) u_dut15 (
        .clk                 (clk),
        .rst                 (rst),
        .qed_enable          (b_enable),
        .force_dup           (1'b0),
        .IF_stall            (1'b0),
        .ifu_qed_instruction (b_instr),
        .exec_dup            (b_exec_dup),
        .qed_check           (b_qed_check),
        .occupancy           (b_occupancy),
        .round_cnt           (b_round_cnt),
        .state               (b_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Let the drain window run out and confirm the check pulse lands on cycle 5
    task automatic drain_and_check(input string tag, input logic [1:0] next_state,
                                   input logic [15:0] exp_round);
        step(4);
        check({tag, "_drain_state"}, 32'(state), 32'd3);
        check({tag, "_no_early_chk"}, 32'(qed_check), 32'd0);
        step(1);
        check({tag, "_qed_check"}, 32'(qed_check), 32'd1);
        check({tag, "_round"}, 32'(round_cnt), 32'(exp_round));
        check({tag, "_post_state"}, 32'(state), 32'(next_state));
        check({tag, "_exec_fall"}, 32'(exec_dup), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        b_dup_entries = 0;
        rst = 1'b0;
        qed_enable = 1'b0;
        force_dup = 1'b0;
        if_stall = 1'b0;
        instr = I_NOP;
        b_enable = 1'b0;
        b_instr = I_NOP;

        #12;
        check("rst_state", 32'(state), 32'd0);
        check("rst_exec", 32'(exec_dup), 32'd0);
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_round", 32'(round_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step(1);

        // Budget 15 instance: fills to capacity and enters DUP exactly once
        b_enable = 1'b1;
        b_instr = I_ADD;
        step(1);
        check("b_orig", 32'(b_state), 32'd1);
        for (int i = 1; i <= 15; i++) begin
            step(1);
            if (b_state == 2'd2 && i < 15) b_dup_entries++;
        end
        check("b_occ_full", 32'(b_occupancy), 32'd15);
        check("b_dup", 32'(b_state), 32'd2);
        check("b_exec", 32'(b_exec_dup), 32'd1);
        b_enable = 1'b0;
        step(1);
        check("b_extra_not_counted", 32'(b_occupancy), 32'd14);
        check("b_stay_dup", 32'(b_state), 32'd2);
        check("b_no_early_dup", 32'(b_dup_entries), 32'd0);

        // Basic round: 8 inserts, 8 deletes, drain
        qed_enable = 1'b1;
        instr = I_ADD;
        step(1);
        check("t1_orig", 32'(state), 32'd1);
        step(7);
        check("t1_occ7", 32'(occupancy), 32'd7);
        check("t1_exec_low", 32'(exec_dup), 32'd0);
        step(1);
        check("t1_occ8", 32'(occupancy), 32'd8);
        check("t1_dup", 32'(state), 32'd2);
        check("t1_exec_rise", 32'(exec_dup), 32'd1);
        step(7);
        check("t1_occ1", 32'(occupancy), 32'd1);
        instr = I_NOP;
        step(1);
        check("t1_occ0", 32'(occupancy), 32'd0);
        check("t1_drain", 32'(state), 32'd3);
        check("t1_exec_drain", 32'(exec_dup), 32'd1);
        drain_and_check("t1", 2'd1, 16'd1);
        step(1);
        check("t1_pulse_one", 32'(qed_check), 32'd0);

        // force_dup on empty cache ignored; then early switch with a stalled delete
        force_dup = 1'b1;
        step(1);
        check("t3_force_empty", 32'(state), 32'd1);
        force_dup = 1'b0;
        instr = I_ADD;
        step(3);
        check("t3_occ3", 32'(occupancy), 32'd3);
        instr = I_NOP;
        force_dup = 1'b1;
        step(1);
        check("t3_forced_dup", 32'(state), 32'd2);
        force_dup = 1'b0;
        step(1);
        check("t3_occ2", 32'(occupancy), 32'd2);
        if_stall = 1'b1;
        step(1);
        check("t3_stall_occ", 32'(occupancy), 32'd2);
        check("t3_stall_state", 32'(state), 32'd2);
        if_stall = 1'b0;
        step(1);
        check("t3_occ1", 32'(occupancy), 32'd1);
        step(1);
        check("t3_occ0", 32'(occupancy), 32'd0);
        drain_and_check("t3", 2'd1, 16'd2);

        // Timeout: 2 inserts then NOPs; DUP on the 64th edge after the last insert
        instr = I_ADD;
        step(2);
        instr = I_NOP;
        step(63);
        check("t4_pre_timeout", 32'(state), 32'd1);
        step(1);
        check("t4_timeout_dup", 32'(state), 32'd2);
        check("t4_occ", 32'(occupancy), 32'd2);
        step(2);
        check("t4_drain", 32'(state), 32'd3);
        drain_and_check("t4", 2'd1, 16'd3);

        // Interleaved NOPs and stalled fetches never restart the timeout
        instr = I_ADD;
        step(1);
        for (int i = 0; i < 63; i++) begin
            instr = (i % 2 == 0) ? I_NOP : I_ADD;
            if_stall = (i % 2 == 1);
            step(1);
        end
        if_stall = 1'b0;
        instr = I_NOP;
        check("t4b_pre_timeout", 32'(state), 32'd1);
        check("t4b_occ", 32'(occupancy), 32'd1);
        step(1);
        check("t4b_timeout_dup", 32'(state), 32'd2);
        step(1);
        drain_and_check("t4b", 2'd1, 16'd4);

        // qed_enable dropped with 4 captured: drain fully, then IDLE
        instr = I_ADD;
        step(4);
        check("t5_occ4", 32'(occupancy), 32'd4);
        instr = I_NOP;
        qed_enable = 1'b0;
        step(1);
        check("t5_dup", 32'(state), 32'd2);
        step(4);
        check("t5_drain", 32'(state), 32'd3);
        drain_and_check("t5", 2'd0, 16'd5);
        step(2);
        check("t5_idle", 32'(state), 32'd0);

        // Asynchronous reset in the middle of DUP
        qed_enable = 1'b1;
        step(1);
        instr = I_ADD;
        step(5);
        instr = I_NOP;
        force_dup = 1'b1;
        step(1);
        force_dup = 1'b0;
        if_stall = 1'b1;
        check("t6_dup_occ5", 32'(occupancy), 32'd5);
        #3;
        rst = 1'b0;
        #1;
        check("t6_async_state", 32'(state), 32'd0);
        check("t6_async_occ", 32'(occupancy), 32'd0);
        check("t6_async_exec", 32'(exec_dup), 32'd0);
        check("t6_async_round", 32'(round_cnt), 32'd0);
        qed_enable = 1'b0;
        if_stall = 1'b0;
        step(2);
        check("t6_no_check", 32'(qed_check), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step(1);
        check("t6_round_after", 32'(round_cnt), 32'd0);
        check("t6_idle_after", 32'(state), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
